act_vec_unit: RTL and testbench

- Parametrised, handshaked activation unit for the fixed-point neural-network datapath. It sits between the neuron MAC/accumulate stage and the next layer's input register.
- Accepts a vector of NCH signed Qx.FRAC_W pre-activations in one beat.
- Evaluates them one element per cycle through a single shared activation evaluator. The function is selected per vector: hard sigmoid, hard tanh, ReLU or pass-through.
- Returns the full result vector with per-channel saturation flags.

---
 rtl/act_vec_unit.sv | 170 +++++++++++++++++
 tb/tb_act_vec_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/act_vec_unit.sv
// Handshaked activation unit: one shared evaluator walks a captured vector
// one channel per cycle and presents the whole result with clamp flags.
module act_vec_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int NCH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_sat,
  output logic                  busy
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int XW    = DATA_W + 1;

  localparam logic signed [XW-1:0] ONE  = XW'(1 << FRAC_W);
  localparam logic signed [XW-1:0] HALF = XW'(1 << (FRAC_W - 1));
  localparam logic signed [XW-1:0] NEG1 = -ONE;
  localparam logic signed [XW-1:0] ZERO = '0;
  localparam logic [IDX_W-1:0]     LAST = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NCH*DATA_W-1:0]   data_q, data_d;
  logic [1:0]              mode_q, mode_d;
  logic [NCH*DATA_W-1:0]   res_q, res_d;
  logic [NCH-1:0]          sat_q, sat_d;

  logic                    accept;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [XW-1:0]    xe;
  logic signed [XW-1:0]    u;
  logic [DATA_W-1:0]       y_cur;
  logic                    sat_cur;

  // Channel mux written as a compare loop so no select can run off the end
  always_comb begin
    x_cur = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        x_cur = data_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Shared evaluator; one guard bit keeps every intermediate exact
  always_comb begin
    xe      = {x_cur[DATA_W-1], x_cur};
    u       = HALF + (xe >>> 2);
    y_cur   = xe[DATA_W-1:0];
    sat_cur = 1'b0;
    case (mode_q)
      2'b00: begin
        if (u < ZERO) begin
          y_cur   = ZERO[DATA_W-1:0];
          sat_cur = 1'b1;
        end else if (u > ONE) begin
          y_cur   = ONE[DATA_W-1:0];
          sat_cur = 1'b1;
        end else begin
          y_cur   = u[DATA_W-1:0];
        end
      end
      2'b01: begin
        if (xe < NEG1) begin
          y_cur   = NEG1[DATA_W-1:0];
          sat_cur = 1'b1;
        end else if (xe > ONE) begin
          y_cur   = ONE[DATA_W-1:0];
          sat_cur = 1'b1;
        end
      end
      2'b10: begin
        if (xe < ZERO) begin
          y_cur = ZERO[DATA_W-1:0];
        end
      end
      default: begin
        y_cur = xe[DATA_W-1:0];
      end
    endcase
  end

  // Ready is forced low while reset is held
  assign in_ready = rst_n &
                    ((state_q == IDLE) |
                     ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mode_d  = mode_q;
    res_d   = res_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        for (int k = 0; k < NCH; k++) begin
          if (idx_q == IDX_W'(k)) begin
            res_d[k*DATA_W +: DATA_W] = y_cur;
            sat_d[k]                  = sat_cur;
          end
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      data_d  = in_data;
      mode_d  = in_mode;
      sat_d   = '0;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      res_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) | (state_q == DONE);
  assign out_data  = res_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_act_vec_unit.sv
// Directed bench for act_vec_unit: vector table plus handshake,
// back-to-back, mode-hold and async-reset sequences.
module tb_act_vec_unit;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_mode = 2'b00;
  logic [N*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_sat;
  logic            busy;

  act_vec_unit #(.DATA_W(DW), .FRAC_W(FW), .NCH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [63:0] x;
    logic [63:0] y;
    logic [3:0]  sat;
  } vec_t;

  vec_t tbl [8];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] pk(input int a0, input int a1,
                                     input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  task automatic set(input int i, input string nm, input logic [1:0] m,
                     input logic [63:0] x, input logic [63:0] y,
                     input logic [3:0] s);
    tbl[i].name = nm;
    tbl[i].mode = m;
    tbl[i].x    = x;
    tbl[i].y    = y;
    tbl[i].sat  = s;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({nm, " latency"}, 128'(cyc), 128'(N));
  endtask

  task automatic drain;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {out_valid, in_ready, busy, out_sat, out_data},
        {1'b0, 1'b0, 1'b0, 4'b0000, 64'h0});
  endtask

  logic [63:0] d0;
  logic [3:0]  s0;

  initial begin
    set(0, "sig_exact", 2'b00, pk(0, 256, -4, -512),
        pk(128, 192, 127, 0), 4'b0000);
    set(1, "sig_clamp", 2'b00, pk(600, -600, 511, -513),
        pk(256, 0, 255, 0), 4'b1011);
    set(2, "tanh", 2'b01, pk(300, -100, 256, -257),
        pk(256, -100, 256, -256), 4'b1001);
    set(3, "relu", 2'b10, pk(300, -100, 256, -257),
        pk(300, 0, 256, 0), 4'b0000);
    set(4, "pass", 2'b11, pk(300, -100, 256, -257),
        pk(300, -100, 256, -257), 4'b0000);
    set(5, "sig_edge", 2'b00, pk(32767, -32768, 512, 515),
        pk(256, 0, 256, 256), 4'b0011);
    set(6, "tanh_edge", 2'b01, pk(-256, 257, 0, 32767),
        pk(-256, 256, 0, 256), 4'b1010);
    set(7, "relu_edge", 2'b10, pk(-1, 1, 32767, -32768),
        pk(0, 1, 32767, 0), 4'b0000);

    #1;
    chk_reset("reset_state");
    step();
    step();
    chk_reset("reset_held");
    rst_n = 1'b1;
    step();
    chk("post_reset", {in_ready, busy, out_valid}, 3'b100);

    for (int i = 0; i < 8; i++) begin
      chk({tbl[i].name, " ready"}, 128'(in_ready), 128'(1));
      send(tbl[i].mode, tbl[i].x);
      chk({tbl[i].name, " busy"}, {busy, out_valid, in_ready}, 3'b100);
      wait_out(tbl[i].name);
      chk({tbl[i].name, " data"}, 128'(out_data), 128'(tbl[i].y));
      chk({tbl[i].name, " sat"}, 128'(out_sat), 128'(tbl[i].sat));
      drain();
      chk({tbl[i].name, " drop"}, {out_valid, busy}, 2'b00);
    end

    // Backpressure, then back-to-back accept on release
    send(tbl[0].mode, tbl[0].x);
    wait_out("bp");
    d0 = tbl[0].y;
    s0 = tbl[0].sat;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp hold", {out_valid, in_ready, out_sat, out_data},
          {1'b1, 1'b0, s0, d0});
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = tbl[2].mode;
    in_data   = tbl[2].x;
    #1;
    chk("b2b ready", 128'(in_ready), 128'(1));
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b gap", {out_valid, busy}, 2'b01);
    wait_out("b2b");
    chk("b2b data", 128'(out_data), 128'(tbl[2].y));
    chk("b2b sat", 128'(out_sat), 128'(tbl[2].sat));
    drain();

    // Inputs changed during RUN must be ignored
    send(2'b00, tbl[1].x);
    in_mode = 2'b01;
    in_data = pk(1, 2, 3, 4);
    wait_out("hold");
    chk("hold data", 128'(out_data), 128'(tbl[1].y));
    chk("hold sat", 128'(out_sat), 128'(tbl[1].sat));
    drain();

    // Async reset between edges in the middle of RUN
    send(2'b11, pk(11, 22, 33, 44));
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    step();
    chk_reset("async_rst held");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("no pulse", {out_valid, busy}, 2'b00);
      step();
    end
    chk("rst ready", 128'(in_ready), 128'(1));
    send(tbl[7].mode, tbl[7].x);
    wait_out("fresh");
    chk("fresh data", 128'(out_data), 128'(tbl[7].y));
    chk("fresh sat", 128'(out_sat), 128'(tbl[7].sat));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
